// File: rtl/boutons_pkg.sv
// Shared constants for the two-button PIO poller: FSM encoding and PIO addresses.
package boutons_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_LAT  = 2'd2;
    localparam logic [1:0] ST_CAP  = 2'd3;

    localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
    localparam logic [1:0] PIO_ADDR_IDLE = 2'd1;

    localparam int DEB_CNT_W = 4;

    // A poll starts only from IDLE; once started it always runs to completion.
    function automatic logic [1:0] poll_next_state(input logic [1:0] state, input logic tick);
        logic [1:0] nxt;
        nxt = ST_IDLE;
        case (state)
            ST_IDLE: nxt = tick ? ST_REQ : ST_IDLE;
            ST_REQ:  nxt = ST_LAT;
            ST_LAT:  nxt = ST_CAP;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/boutons_debounce.sv
// Single-button debouncer: a new level is accepted after STABLE_N consecutive
// differing samples; o_rise/o_fall flag the accepted change during the sampling cycle.
module boutons_debounce import boutons_pkg::*; #(
    parameter int STABLE_N = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_sample_valid,
    input  logic i_sample,
    output logic o_state,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(STABLE_N);

    logic [DEB_CNT_W-1:0] r_cnt;
    logic                 r_state;
    logic                 w_differs;
    logic                 w_settle;

    assign w_differs = i_sample_valid && (i_sample != r_state);
    assign w_settle  = w_differs && ((r_cnt + DEB_CNT_W'(1)) == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_state <= 1'b0;
        end else if (i_sample_valid) begin
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_settle) begin
                r_cnt   <= '0;
                r_state <= ~r_state;
            end else begin
                r_cnt <= r_cnt + DEB_CNT_W'(1);
            end
        end
    end

    assign o_state = r_state;
    assign o_rise  = w_settle && !r_state;
    assign o_fall  = w_settle && r_state;

endmodule

// File: rtl/boutons_poll_ctrl.sv
// Periodically reads two buttons from a PIO slave, debounces them and reports
// press/release events through a valid/ready handshake with sticky overflow.
module boutons_poll_ctrl import boutons_pkg::*; #(
    parameter int POLL_DIV   = 50000,
    parameter int STABLE_N   = 8,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    output logic [1:0]  pio_address,
    input  logic [31:0] pio_readdata,
    output logic [1:0]  btn_state,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_press,
    output logic [1:0]  evt_release,
    output logic        evt_ovf,
    input  logic        ovf_clr
);

    localparam logic [19:0] DIV_LAST = 20'(POLL_DIV - 1);

    logic [19:0] r_tick_cnt;
    logic [1:0]  r_state;
    logic [1:0]  r_evt_press;
    logic [1:0]  r_evt_release;
    logic        r_evt_valid;
    logic        r_evt_ovf;
    logic        w_tick;
    logic        w_capture;
    logic [1:0]  w_sample;
    logic [1:0]  w_btn_state;
    logic [1:0]  w_rise;
    logic [1:0]  w_fall;
    logic        w_change;
    logic        w_overflow;
    logic        w_unused;

    assign w_unused = ^pio_readdata[31:2];
    assign w_tick   = en && (r_tick_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_cnt <= '0;
        end else if (!en || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 20'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= poll_next_state(r_state, w_tick);
        end
    end

    // Address is held through LAT so the PIO's registered read lands in CAP.
    assign pio_address = (r_state == ST_REQ || r_state == ST_LAT) ? PIO_ADDR_DATA : PIO_ADDR_IDLE;
    assign w_capture   = (r_state == ST_CAP);
    assign w_sample    = (ACTIVE_LOW != 0) ? ~pio_readdata[1:0] : pio_readdata[1:0];

    boutons_debounce #(.STABLE_N(STABLE_N)) u_debounce0 (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_sample_valid (w_capture),
        .i_sample       (w_sample[0]),
        .o_state        (w_btn_state[0]),
        .o_rise         (w_rise[0]),
        .o_fall         (w_fall[0])
    );

    boutons_debounce #(.STABLE_N(STABLE_N)) u_debounce1 (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_sample_valid (w_capture),
        .i_sample       (w_sample[1]),
        .o_state        (w_btn_state[1]),
        .o_rise         (w_rise[1]),
        .o_fall         (w_fall[1])
    );

    assign w_change   = |(w_rise | w_fall);
    assign w_overflow = w_change && r_evt_valid && !evt_ready;

    // An unaccepted event absorbs later changes instead of dropping them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_evt_valid   <= 1'b0;
            r_evt_press   <= 2'b00;
            r_evt_release <= 2'b00;
            r_evt_ovf     <= 1'b0;
        end else begin
            if (w_change) begin
                r_evt_valid <= 1'b1;
                if (!r_evt_valid || evt_ready) begin
                    r_evt_press   <= w_rise;
                    r_evt_release <= w_fall;
                end else begin
                    r_evt_press   <= r_evt_press | w_rise;
                    r_evt_release <= r_evt_release | w_fall;
                end
            end else if (r_evt_valid && evt_ready) begin
                r_evt_valid <= 1'b0;
            end
            if (w_overflow) begin
                r_evt_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_evt_ovf <= 1'b0;
            end
        end
    end

    assign btn_state   = w_btn_state;
    assign evt_valid   = r_evt_valid;
    assign evt_press   = r_evt_press;
    assign evt_release = r_evt_release;
    assign evt_ovf     = r_evt_ovf;

endmodule
